// File: rtl/mole_scheduler.sv
// Mole scheduler: picks each mole position from an 8-bit LFSR and times the
// show/gap windows. The show window shrinks with score and ends early on a correct guess.
module mole_scheduler #(
  parameter int unsigned DWELL_BASE = 20000,
  parameter int unsigned DWELL_STEP = 1000,
  parameter int unsigned DWELL_MIN  = 4000,
  parameter int unsigned GAP_CYCLES = 2000,
  parameter logic [7:0]  SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_restart_game,
  input  logic       i_game_over,
  input  logic       guess_correct,
  input  logic [7:0] score,
  output logic [2:0] mole_pos,
  output logic       mole_change,
  output logic       mole_visible,
  output logic [7:0] moles_spawned
);

  typedef enum logic [1:0] {GAP, SHOW, STOPPED} state_t;

  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [27:0] BASE28   = 28'(DWELL_BASE);
  localparam logic [27:0] STEP28   = 28'(DWELL_STEP);
  localparam logic [27:0] MIN28    = 28'(DWELL_MIN);
  localparam logic [27:0] GAP_LAST = 28'(GAP_CYCLES - 1);

  state_t      state, state_next;
  logic [27:0] cnt, cnt_next;
  logic [27:0] dwell, dwell_next;
  logic [7:0]  lfsr, lfsr_next;
  logic [2:0]  pos_next;
  logic        change_next, visible_next;
  logic [7:0]  spawned_next;
  logic [27:0] product, dwell_calc;
  logic [2:0]  candidate, spawn_pos;

  // Guarding against the product before subtracting keeps the dwell from wrapping.
  always_comb begin
    product    = 28'(score) * STEP28;
    dwell_calc = (product >= (BASE28 - MIN28)) ? MIN28 : (BASE28 - product);
    candidate  = lfsr[2:0];
    spawn_pos  = (candidate == mole_pos) ? (candidate + 3'd1) : candidate;
    lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    dwell_next   = dwell;
    pos_next     = mole_pos;
    change_next  = 1'b0;
    visible_next = mole_visible;
    spawned_next = moles_spawned;

    if (i_restart_game) begin
      state_next   = GAP;
      cnt_next     = '0;
      pos_next     = '0;
      visible_next = 1'b0;
      spawned_next = '0;
    end else if (i_game_over) begin
      state_next   = STOPPED;
      cnt_next     = '0;
      visible_next = 1'b0;
    end else begin
      unique case (state)
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_next   = SHOW;
            cnt_next     = '0;
            pos_next     = spawn_pos;
            change_next  = 1'b1;
            visible_next = 1'b1;
            dwell_next   = dwell_calc;
            if (moles_spawned != 8'hFF) spawned_next = moles_spawned + 8'd1;
          end else begin
            cnt_next = cnt + 28'd1;
          end
        end
        SHOW: begin
          if (guess_correct || (cnt == dwell - 28'd1)) begin
            state_next   = GAP;
            cnt_next     = '0;
            visible_next = 1'b0;
          end else begin
            cnt_next = cnt + 28'd1;
          end
        end
        STOPPED: begin
          visible_next = 1'b0;
        end
        default: state_next = GAP;
      endcase
    end
  end

  // The LFSR keeps shifting through restart and game over; only reset reloads it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= GAP;
      cnt           <= '0;
      dwell         <= BASE28;
      lfsr          <= SEED_EFF;
      mole_pos      <= '0;
      mole_change   <= 1'b0;
      mole_visible  <= 1'b0;
      moles_spawned <= '0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      dwell         <= dwell_next;
      lfsr          <= lfsr_next;
      mole_pos      <= pos_next;
      mole_change   <= change_next;
      mole_visible  <= visible_next;
      moles_spawned <= spawned_next;
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler using small timing parameters
// (base 20, step 2, floor 8, gap 4, seed 01).
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_restart_game;
  logic       i_game_over;
  logic       guess_correct;
  logic [7:0] score;
  logic [2:0] mole_pos;
  logic       mole_change;
  logic       mole_visible;
  logic [7:0] moles_spawned;

  int testsRun = 0;
  int testsFailed = 0;

  mole_scheduler #(
    .DWELL_BASE(20), .DWELL_STEP(2), .DWELL_MIN(8), .GAP_CYCLES(4), .SEED(8'h01)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_restart_game(i_restart_game),
    .i_game_over(i_game_over), .guess_correct(guess_correct), .score(score),
    .mole_pos(mole_pos), .mole_change(mole_change), .mole_visible(mole_visible),
    .moles_spawned(moles_spawned)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until mole_change is seen; n is the number of edges taken, -1 on timeout.
  task automatic waitSpawn(output int n);
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (mole_change) begin
        n = i;
        return;
      end
    end
    n = -1;
  endtask

  // Called right after a spawn edge; returns how many cycles mole_visible stayed high.
  task automatic countHigh(output int len);
    len = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!mole_visible) return;
      len++;
    end
    len = -1;
  endtask

  initial begin
    int n, len, changes, visHigh, repeats, timeouts;
    logic [2:0] prevPos, heldPos;
    logic [7:0] seen;

    rst_n = 1'b0; i_restart_game = 1'b0; i_game_over = 1'b0;
    guess_correct = 1'b0; score = 8'd0;
    tick(); tick();
    checkOutput("rstPos", mole_pos, 0);
    checkOutput("rstChange", mole_change, 0);
    checkOutput("rstVisible", mole_visible, 0);
    checkOutput("rstSpawned", moles_spawned, 0);

    // Reset release, score 0: spawn at edge 4, then 20 high / 4 low
    rst_n = 1'b1;
    waitSpawn(n);
    checkOutput("firstSpawnEdge", n, 4);
    checkOutput("firstPos", mole_pos, 1);
    checkOutput("firstVisible", mole_visible, 1);
    checkOutput("spawned1", moles_spawned, 1);
    countHigh(len);
    checkOutput("show1", len, 20);
    waitSpawn(n);
    checkOutput("gap1", n, 4);
    checkOutput("spawned2", moles_spawned, 2);
    countHigh(len);
    checkOutput("show2", len, 20);
    waitSpawn(n);
    checkOutput("gap2", n, 4);
    checkOutput("spawned3", moles_spawned, 3);

    // Dwell scaling, including a score change in the middle of a show
    score = 8'd6;
    countHigh(len);
    checkOutput("midShowScoreKeeps20", len, 20);
    waitSpawn(n);
    countHigh(len);
    checkOutput("score6Dwell", len, 8);
    score = 8'd3;
    waitSpawn(n);
    countHigh(len);
    checkOutput("score3Dwell", len, 14);
    score = 8'd200;
    waitSpawn(n);
    countHigh(len);
    checkOutput("score200Clamp", len, 8);

    // Correct guess at cnt 5 gives 6 visible cycles
    score = 8'd0;
    waitSpawn(n);
    checkOutput("gapBeforeGuess", n, 4);
    len = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mole_visible) len++;
    end
    checkOutput("visibleBeforeGuess", len, 6);
    guess_correct = 1'b1;
    tick();
    guess_correct = 1'b0;
    checkOutput("guessHides", mole_visible, 0);
    waitSpawn(n);
    checkOutput("gapAfterGuess", n, 4);
    countHigh(len);
    checkOutput("showAfterGuess", len, 20);

    // Guess during the gap is ignored
    tick();
    guess_correct = 1'b1;
    tick();
    guess_correct = 1'b0;
    waitSpawn(n);
    checkOutput("gapGuessIgnored", n, 2);
    countHigh(len);
    checkOutput("showAfterGapGuess", len, 20);

    // 300 spawns: no repeats, all positions, counter saturates
    score = 8'd200;
    prevPos = mole_pos;
    seen = '0; repeats = 0; timeouts = 0;
    for (int s = 0; s < 300; s++) begin
      waitSpawn(n);
      if (n < 0) begin
        timeouts++;
        break;
      end
      if (mole_pos == prevPos) repeats++;
      prevPos = mole_pos;
      seen[mole_pos] = 1'b1;
    end
    checkOutput("spawnTimeouts", timeouts, 0);
    checkOutput("repeatPositions", repeats, 0);
    checkOutput("allPositionsSeen", seen, 255);
    checkOutput("spawnedSaturates", moles_spawned, 255);

    // Game over mid-show
    tick(); tick();
    heldPos = mole_pos;
    i_game_over = 1'b1;
    tick();
    checkOutput("gameOverHides", mole_visible, 0);
    changes = 0; visHigh = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (mole_change) changes++;
      if (mole_visible) visHigh++;
    end
    checkOutput("gameOverNoChange", changes, 0);
    checkOutput("gameOverNoVisible", visHigh, 0);
    checkOutput("gameOverPosHeld", mole_pos, heldPos);
    checkOutput("gameOverSpawnedHeld", moles_spawned, 255);

    // STOPPED persists after game over drops; restart leaves it
    i_game_over = 1'b0;
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mole_change) changes++;
    end
    checkOutput("stoppedStays", changes, 0);
    i_restart_game = 1'b1;
    tick();
    i_restart_game = 1'b0;
    checkOutput("restartSpawned", moles_spawned, 0);
    checkOutput("restartPos", mole_pos, 0);
    waitSpawn(n);
    checkOutput("restartSpawnEdge", n, 4);
    checkOutput("restartSpawned1", moles_spawned, 1);

    // Reset mid-show clears outputs and reloads the LFSR
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midRstPos", mole_pos, 0);
    checkOutput("midRstVisible", mole_visible, 0);
    checkOutput("midRstSpawned", moles_spawned, 0);
    rst_n = 1'b1;
    waitSpawn(n);
    checkOutput("midRstSpawnEdge", n, 4);
    checkOutput("midRstReloadPos", mole_pos, 1);

    // Restart and game over together: restart wins
    tick(); tick();
    i_restart_game = 1'b1;
    i_game_over = 1'b1;
    tick();
    i_restart_game = 1'b0;
    i_game_over = 1'b0;
    checkOutput("bothSpawned", moles_spawned, 0);
    checkOutput("bothVisible", mole_visible, 0);
    waitSpawn(n);
    checkOutput("bothSpawnEdge", n, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
